// File: rtl/comparator_seq.sv
// comparator_seq
//   Multi-cycle magnitude comparator for wide operands. On start it captures
//   a/b/s, then compares W-bit chunks from MSB to LSB, one per cycle, and
//   stops at the first chunk that differs. The result is the six-flag word
//   {eq, neq, lt, lte, gt, gte}. It reports how many chunks it examined.
//
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled only while idle
//   abort  in   cancels a running compare; blocks start while idle
//   s      in   1 = signed (two's complement), 0 = unsigned
//   a, b   in   N-bit operands
//   busy   out  high while a compare is running
//   done   out  one-cycle pulse; o/cyc hold a new result
//   o      out  result flags {eq, neq, lt, lte, gt, gte}
//   cyc    out  chunks examined by the last completed compare (1..K)

module comparator_seq #(
  parameter int N = 32,
  parameter int W = 8,
  localparam int K    = N / W,
  localparam int CYCW = $clog2(K + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            s,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic [5:0]      o,
  output logic [CYCW-1:0] cyc
);

  localparam int IDXW = (K > 1) ? $clog2(K) : 1;

  localparam logic [5:0] FLAGS_LT = 6'b011100;
  localparam logic [5:0] FLAGS_EQ = 6'b100101;
  localparam logic [5:0] FLAGS_GT = 6'b010011;

  if ((N % W) != 0) begin : g_bad_width
    $error("comparator_seq: N (%0d) must be a multiple of W (%0d)", N, W);
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [N-1:0]      ra_q;
  logic [N-1:0]      rb_q;
  logic              rs_q;
  logic [IDXW-1:0]   idx_q;
  logic              busy_q;
  logic              done_q;
  logic [5:0]        o_q;
  logic [CYCW-1:0]   cyc_q;

  // Current chunk pair, taken from the captured operands
  logic [31:0]       shamt_d;
  logic [N-1:0]      ra_sh_d;
  logic [N-1:0]      rb_sh_d;
  logic [W-1:0]      ca_d;
  logic [W-1:0]      cb_d;
  logic              chunk_ne_d;
  logic              chunk_lt_d;

  always_comb begin
    shamt_d = 32'(idx_q) * 32'(W);
    ra_sh_d = ra_q >> shamt_d;
    rb_sh_d = rb_q >> shamt_d;
    ca_d    = ra_sh_d[W-1:0];
    cb_d    = rb_sh_d[W-1:0];
    // Flipping the sign bit of the top chunk maps two's complement order
    // onto unsigned order; all lower chunks are plain unsigned magnitudes.
    if (rs_q && (idx_q == IDXW'(K - 1))) begin
      ca_d[W-1] = ~ca_d[W-1];
      cb_d[W-1] = ~cb_d[W-1];
    end
    chunk_ne_d = (ca_d != cb_d);
    chunk_lt_d = (ca_d < cb_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= 1'b0;
      idx_q   <= IDXW'(K - 1);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      o_q     <= '0;
      cyc_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            ra_q    <= a;
            rb_q    <= b;
            rs_q    <= s;
            idx_q   <= IDXW'(K - 1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (chunk_ne_d) begin
            o_q     <= chunk_lt_d ? FLAGS_LT : FLAGS_GT;
            cyc_q   <= CYCW'(K) - CYCW'(idx_q);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (idx_q == '0) begin
            o_q     <= FLAGS_EQ;
            cyc_q   <= CYCW'(K);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign o    = o_q;
  assign cyc  = cyc_q;

endmodule

// File: tb/tb_comparator_seq.sv
module tb_comparator_seq;

  localparam logic [5:0] LT = 6'b011100;
  localparam logic [5:0] EQ = 6'b100101;
  localparam logic [5:0] GT = 6'b010011;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        s;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [5:0]  o;
  logic [2:0]  cyc;

  comparator_seq #(.N(32), .W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .s     (s),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .o     (o),
    .cyc   (cyc)
  );

  typedef struct {
    logic [5:0] o;
    logic [2:0] cyc;
    int         t0;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cnt = 0;
  logic [5:0]  prev_o;
  logic [2:0]  prev_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cnt = cnt + 1;
  end

  // Monitor: pops the scoreboard whenever the DUT presents done
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_done: o=%b cyc=%0d at cycle %0d", o, cyc, cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks = checks + 4;
        if (o !== e.o) begin
          errors = errors + 1;
          $display("FAIL flags: got %b expected %b", o, e.o);
        end
        if (cyc !== e.cyc) begin
          errors = errors + 1;
          $display("FAIL cyc: got %0d expected %0d", cyc, e.cyc);
        end
        if (cnt - e.t0 != int'(e.cyc)) begin
          errors = errors + 1;
          $display("FAIL latency: got %0d cycles expected %0d", cnt - e.t0, e.cyc);
        end
        if (busy !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL busy_with_done: busy=%b expected 0", busy);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] eo, input logic [2:0] ec);
    exp_t e;
    e.o   = eo;
    e.cyc = ec;
    e.t0  = cnt;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                       input logic [5:0] eo, input logic [2:0] ec);
    @(negedge clk);
    a = av; b = bv; s = sv; start = 1'b1;
    @(posedge clk);
    #1;
    push(eo, ec);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_empty(10);
    prev_o   = eo;
    prev_cyc = ec;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s = 1'b0; a = '0; b = '0;
    prev_o = '0; prev_cyc = '0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_o",    {26'd0, o},    32'd0);
    chk("rst_cyc",  {29'd0, cyc},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'h0000_0000, 32'h0000_0001, 1'b0, LT, 3'd4);
    issue(32'h0000_0000, 32'h0000_0001, 1'b1, LT, 3'd4);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, GT, 3'd1);
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, LT, 3'd1);
    issue(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, EQ, 3'd4);
    issue(32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0, LT, 3'd4);
    issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, LT, 3'd4);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, LT, 3'd1);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, GT, 3'd1);
    // 0x00010000 vs 0x00020000: byte 3 equal, byte 2 (0x01 vs 0x02) differs
    issue(32'h0001_0000, 32'h0002_0000, 1'b0, LT, 3'd2);
    // byte 1 differs -> third chunk examined
    issue(32'h0000_0300, 32'h0000_0200, 1'b1, GT, 3'd3);

    // Abort in the second RUN cycle: no done, results keep previous values
    @(negedge clk);
    a = '0; b = '0; s = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("busy_after_abort", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_o_kept",   {26'd0, o},   {26'd0, prev_o});
    chk("abort_cyc_kept", {29'd0, cyc}, {29'd0, prev_cyc});

    // Abort while idle blocks start
    @(negedge clk);
    a = 32'd1; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_blocks_start", {31'd0, busy}, 32'd1 - 32'd1);
    repeat (6) @(negedge clk);

    // start held through RUN: no restart; operand changes during RUN ignored;
    // start still high one cycle after done is accepted
    @(negedge clk);
    a = '0; b = '0; s = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    push(EQ, 3'd4);
    @(negedge clk);
    a = 32'd5; b = 32'd3;
    repeat (4) @(posedge clk);
    @(posedge clk);
    #1;
    push(GT, 3'd4);
    @(negedge clk);
    start = 1'b0;
    wait_empty(12);

    // Reset asserted between edges during RUN
    @(negedge clk);
    a = 32'd0; b = 32'd1; s = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_o",    {26'd0, o},    32'd0);
    chk("midrun_rst_cyc",  {29'd0, cyc},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    issue(32'd5, 32'd3, 1'b0, GT, 3'd4);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
